serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; the clock port SHALL be clk and the reset port SHALL be rst_n.
REQ-002 Parameter: WIDTH, default 8, operand/result width in bits; legal range 1..64.
REQ-003 Ports (name  direction  width  meaning), one per line:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a new operation; accepted only when ready=1
- sub  input  1  0 = add, 1 = subtract (a - b); sampled with start
- carry_in  input  1  carry into bit 0 in add mode; sampled with start; ignored when sub=1
- a  input  WIDTH  operand A; sampled with start
- b  input  WIDTH  operand B; sampled with start
- ready  output  1  high when idle and able to accept start
- done  output  1  one-cycle pulse when a result becomes valid
- sum  output  WIDTH  result of the last completed operation
- carry  output  1  carry-out of the last completed operation (add: carry; sub: 1 = no borrow)

Function
REQ-004 The block SHALL compute one result bit per clock, LSB first, using a single 1-bit full-add slice.
REQ-005 The state machine SHALL have two states: IDLE (ready=1) and RUN (ready=0).
REQ-006 A rising edge with state=IDLE and start=1 SHALL do the following in one step:
- load a into the A shift register
- load b (sub=0) or ~b (sub=1) into the B shift register
- load the internal carry with carry_in (sub=0) or 1 (sub=1)
- clear the bit counter
- enter RUN
REQ-007 At each RUN edge, the slice SHALL add A[0], B[0] and the internal carry, then:
- shift the sum bit into the MSB of the internal result register
- shift A and B right by one
- store the carry-out
- increment the counter
REQ-008 At the RUN edge where the counter equals WIDTH-1, the block SHALL:
- copy the completed internal result to sum
- copy the final carry-out to carry
- assert done for exactly one cycle
- return to IDLE with ready=1
REQ-009 Latency: done SHALL be high in the cycle following the WIDTH-th edge after the accepting edge; for WIDTH=8, start accepted at edge 0 gives done high after edge 8.
REQ-010 sum and carry SHALL change only at completion (REQ-008) or reset, and SHALL hold their value through subsequent RUN periods.
REQ-011 start while in RUN SHALL be ignored, with no effect on operands, counter or outputs.
REQ-012 start=1 in the cycle where done=1 (ready=1) SHALL be accepted, enabling back-to-back operations with no idle cycle; done SHALL deassert on the next edge.
REQ-013 Results SHALL be modulo 2^WIDTH; the counter width SHALL be max(1, clog2(WIDTH)); WIDTH=1 SHALL complete in one RUN cycle.

Reset
REQ-014 With rst_n=0, the block SHALL immediately, regardless of clk, force:
- state to IDLE
- ready=1, done=0, sum=0, carry=0
- all internal shift registers and the counter to 0
REQ-015 Reset asserted during RUN SHALL abort the operation; no done pulse SHALL follow for it.
REQ-016 After rst_n deasserts, the first rising edge SHALL be able to accept start.

Structure
REQ-017 The state encodings (IDLE, RUN) and the default WIDTH SHALL be defined in a shared package, not inside the module.
REQ-018 The 1-bit slice SHALL be a separate combinational sub-module, full_adder, with ports a, b, carry_in, sum, carry, instantiated once.

Verification
REQ-019 The bench SHALL cover, with WIDTH=8:
- Reset: after rst_n low → ready=1, done=0, sum=8'h00, carry=0.
- Add: a=8'h0F, b=8'h01, sub=0, carry_in=0, start at edge 0 → done pulses after edge 8 only, sum=8'h10, carry=0.
- Carry: a=8'hFF, b=8'h01 → sum=8'h00, carry=1; then a=8'hFF, b=8'hFF, carry_in=1 → sum=8'hFF, carry=1.
- Subtract: a=8'h05, b=8'h07, sub=1 → sum=8'hFE, carry=0; then a=8'h07, b=8'h05 → sum=8'h02, carry=1.
- Handshake: start pulsed mid-RUN is ignored and the result is unchanged; start held during the done cycle gives a second done exactly 8 cycles later; sum holds the old value until then.
- Reset mid-op: rst_n low after edge 4 of RUN → immediate ready=1, sum=8'h00, and no done pulse for the aborted operation.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: state encoding,
// default operand width and the bit-counter sizing rule.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // A 1-bit operand still needs a 1-bit counter.
    function automatic int cnt_width(input int width);
        return (width <= 1) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// Single-bit combinational full-add slice reused for every result bit.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic carry_in,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ carry_in;
    assign carry = (a & b) | (carry_in & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one result bit per clock, LSB first, through a
// single full-add slice. Subtraction is a + ~b + 1, so carry=1 means no borrow.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic             carry_in,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    localparam int             CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    // Handshake: an operation is accepted on a rising edge where start=1 and
    // ready=1; start is ignored while ready=0. done is a single-cycle pulse
    // that coincides with ready=1, so a new start may be presented with it.

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             carry_q, carry_d;
    logic             done_q, done_d;

    logic             fa_sum;
    logic             fa_carry;
    logic [WIDTH-1:0] res_shift;

    full_adder u_fa (
        .a        (a_q[0]),
        .b        (b_q[0]),
        .carry_in (c_q),
        .sum      (fa_sum),
        .carry    (fa_carry)
    );

    // New sum bit enters at the MSB so the word is aligned after WIDTH shifts.
    generate
        if (WIDTH == 1) begin : g_res_w1
            assign res_shift = fa_sum;
        end else begin : g_res_wn
            assign res_shift = {fa_sum, res_q[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        carry_d = carry_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    c_d     = sub ? 1'b1 : carry_in;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                res_d = res_shift;
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                c_d   = fa_carry;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    sum_d   = res_shift;
                    carry_d = fa_carry;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            carry_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            carry_q <= carry_d;
            done_q  <= done_d;
        end
    end

    assign ready = (state_q == IDLE);
    assign done  = done_q;
    assign sum   = sum_q;
    assign carry = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): vector table, random ops and
// hand-written handshake / reset corner cases, with a result scoreboard.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic         carry_in;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ready;
    logic         done;
    logic [W-1:0] sum;
    logic         carry;

    int checks = 0;
    int errors = 0;

    logic [W:0] exp_q[$];

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic         cin;
        logic [W-1:0] exp_sum;
        logic         exp_carry;
    } vec_t;

    vec_t vecs[12];

    serial_adder #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .sub      (sub),
        .carry_in (carry_in),
        .a        (a),
        .b        (b),
        .ready    (ready),
        .done     (done),
        .sum      (sum),
        .carry    (carry)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1);
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic s, input logic ci);
        if (s)
            return {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    endfunction

    // ---------------- scoreboard ----------------
    logic [W:0] mon_exp;
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done_unexpected got done=1 want done=0 at %0t", $time);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("result", {55'd0, carry, sum}, {55'd0, mon_exp});
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic drive_start(input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                               input logic sub_i, input logic cin_i, input logic [W:0] exp);
        start    = 1'b1;
        a        = a_i;
        b        = b_i;
        sub      = sub_i;
        carry_in = cin_i;
        exp_q.push_back(exp);
    endtask

    // Called at the negedge that is n0 edges past the accepting edge.
    task automatic wait_done(input int n0, input string name);
        int n;
        n = n0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(name, 64'(n), 64'(W));
    endtask

    task automatic run_op(input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                          input logic sub_i, input logic cin_i, input logic [W:0] exp,
                          input bit poke_mid);
        @(negedge clk);
        chk("ready_idle", 64'(ready), 64'd1);
        drive_start(a_i, b_i, sub_i, cin_i, exp);
        @(negedge clk);
        start = 1'b0;
        if (poke_mid) begin
            repeat (3) @(negedge clk);
            chk("ready_run", 64'(ready), 64'd0);
            start    = 1'b1;
            a        = ~a_i;
            b        = 8'h5A;
            sub      = ~sub_i;
            carry_in = 1'b1;
            @(negedge clk);
            start = 1'b0;
            wait_done(4, "latency_poke");
        end else begin
            wait_done(0, "latency");
        end
    endtask

    // ---------------- test ----------------
    initial begin
        vecs[0]  = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0};
        vecs[1]  = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1};
        vecs[2]  = '{8'hFF, 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b1};
        vecs[3]  = '{8'h05, 8'h07, 1'b1, 1'b0, 8'hFE, 1'b0};
        vecs[4]  = '{8'h07, 8'h05, 1'b1, 1'b0, 8'h02, 1'b1};
        vecs[5]  = '{8'h10, 8'h01, 1'b1, 1'b1, 8'h0F, 1'b1};
        vecs[6]  = '{8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1};
        vecs[7]  = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1};
        vecs[8]  = '{8'hAA, 8'h55, 1'b0, 1'b1, 8'h00, 1'b1};
        vecs[9]  = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h01, 1'b0};
        vecs[10] = '{8'hA5, 8'h5A, 1'b1, 1'b0, 8'h4B, 1'b1};
        vecs[11] = '{8'h00, 8'h01, 1'b1, 1'b0, 8'hFF, 1'b0};

        rst_n    = 1'b1;
        start    = 1'b0;
        sub      = 1'b0;
        carry_in = 1'b0;
        a        = '0;
        b        = '0;

        #2 rst_n = 1'b0;
        #1;
        chk("rst_ready", 64'(ready), 64'd1);
        chk("rst_done",  64'(done),  64'd0);
        chk("rst_sum",   64'(sum),   64'h00);
        chk("rst_carry", 64'(carry), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Table-driven vectors; each result must be a single-cycle pulse.
        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin,
                   {vecs[i].exp_carry, vecs[i].exp_sum}, 1'b0);
            @(negedge clk);
            chk("done_one_cycle", 64'(done), 64'd0);
            chk("sum_hold", {55'd0, carry, sum}, {55'd0, vecs[i].exp_carry, vecs[i].exp_sum});
        end

        // Random operations against the arithmetic model.
        for (int i = 0; i < 16; i++) begin
            logic [W-1:0] ra, rb;
            logic         rs, rc;
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(0, 255));
            rs = 1'($urandom_range(0, 1));
            rc = 1'($urandom_range(0, 1));
            run_op(ra, rb, rs, rc, model(ra, rb, rs, rc), 1'b0);
        end

        // start pulsed mid-RUN must not disturb the operation in flight.
        run_op(8'h0F, 8'h01, 1'b0, 1'b0, {1'b1 == 1'b0, 8'h10}, 1'b1);
        repeat (12) @(negedge clk);
        chk("poke_no_extra_op", 64'(ready), 64'd1);
        chk("poke_sum_hold", 64'(sum), 64'h10);

        // Back-to-back: start presented in the done cycle.
        run_op(8'h33, 8'h44, 1'b0, 1'b0, model(8'h33, 8'h44, 1'b0, 1'b0), 1'b0);
        chk("b2b_ready_on_done", 64'(ready), 64'd1);
        drive_start(8'h07, 8'h05, 1'b1, 1'b0, model(8'h07, 8'h05, 1'b1, 1'b0));
        @(negedge clk);
        start = 1'b0;
        chk("b2b_done_drop", 64'(done), 64'd0);
        chk("b2b_ready_drop", 64'(ready), 64'd0);
        repeat (4) @(negedge clk);
        chk("b2b_sum_hold", {55'd0, carry, sum}, {55'd0, 1'b0, 8'h77});
        wait_done(4, "b2b_latency");
        @(negedge clk);

        // Reset after RUN edge 4 aborts; no done for the aborted operation.
        chk("abort_ready_idle", 64'(ready), 64'd1);
        drive_start(8'h3C, 8'h11, 1'b0, 1'b0, model(8'h3C, 8'h11, 1'b0, 1'b0));
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_ready_run", 64'(ready), 64'd0);
        rst_n = 1'b0;
        #1;
        chk("abort_ready", 64'(ready), 64'd1);
        chk("abort_done",  64'(done),  64'd0);
        chk("abort_sum",   64'(sum),   64'h00);
        chk("abort_carry", 64'(carry), 64'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        drive_start(8'hC8, 8'h64, 1'b0, 1'b1, model(8'hC8, 8'h64, 1'b0, 1'b1));
        @(negedge clk);
        start = 1'b0;
        wait_done(0, "post_reset_latency");
        repeat (12) @(negedge clk);
        chk("final_sum_hold", {55'd0, carry, sum}, {55'd0, 1'b1, 8'h2D});
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
